// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed LDR/STR{,B,H} onto a word-addressed memory, sub-word stores via read-modify-write.
// Latency: fault 1 cycle, load/word store 2, sub-word store 3 (Req to Done); Req is only sampled while Ready=1.
module load_store_unit #(
  parameter int MEM_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Req,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ready,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] RData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_STORE     = 3'd2;
  localparam logic [2:0] S_RMW_READ  = 3'd3;
  localparam logic [2:0] S_RMW_WRITE = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_maddr;
  logic [31:0] r_mwdata;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_fault;

  logic [31:0] w_idx;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_idx = {2'b00, Addr[31:2]};

  always_comb begin
    w_fault = 1'b0;
    if (Size == 2'b11) w_fault = 1'b1;
    if (Size == 2'b01 && Addr[0]) w_fault = 1'b1;
    if (Size == 2'b10 && Addr[1:0] != 2'b00) w_fault = 1'b1;
    if (w_idx >= 32'(MEM_DEPTH)) w_fault = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores share the latched byte offset.
  always_comb begin
    w_byte  = MemReadData[{r_lane, 3'b000} +: 8];
    w_half  = r_lane[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = MemReadData;
    endcase
    w_merge = MemReadData;
    if (r_size == 2'b00) w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state  <= S_IDLE;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_lane   <= 2'b00;
      r_wdata  <= 16'h0;
      r_maddr  <= 32'h0;
      r_mwdata <= 32'h0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_size  <= Size;
            r_sext  <= SignExt;
            r_lane  <= Addr[1:0];
            r_wdata <= WData[15:0];
            r_maddr <= w_idx;
            if (w_fault) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else if (!Write) begin
              r_state <= S_LOAD;
            end else if (Size == 2'b10) begin
              r_state  <= S_STORE;
              r_mwdata <= WData;
            end else begin
              r_state <= S_RMW_READ;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_STORE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_RMW_READ: begin
          r_mwdata <= w_merge;
          r_state  <= S_RMW_WRITE;
        end
        S_RMW_WRITE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating by RESETn keeps an in-flight store from committing on the reset edge.
  assign MemWrite     = RESETn & ((r_state == S_STORE) | (r_state == S_RMW_WRITE));
  assign Ready        = (r_state == S_IDLE);
  assign Done         = r_done;
  assign Fault        = r_fault;
  assign RData        = r_rdata;
  assign MemAddress   = r_maddr;
  assign MemWriteData = r_mwdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected Done responses, a negedge monitor checks them.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Req = 1'b0;
  logic        Write = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SignExt = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WData = 32'h0;
  logic        Ready, Done, Fault, MemWrite;
  logic [31:0] RData, MemAddress, MemWriteData, MemReadData;

  load_store_unit #(.MEM_DEPTH(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .Req(Req), .Write(Write), .Size(Size),
    .SignExt(SignExt), .Addr(Addr), .WData(WData), .Ready(Ready), .Done(Done),
    .Fault(Fault), .RData(RData), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:7];
  always @(posedge CLK) if (MemWrite === 1'b1 && MemAddress < 8) mem[MemAddress[2:0]] <= MemWriteData;
  assign MemReadData = (MemAddress < 8) ? mem[MemAddress[2:0]] : 32'h0;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          done_cyc;
    int          nwr;
    logic [31:0] wdat;
    logic [31:0] waddr;
    int          gap;
    int          id;
  } exp_t;

  localparam int P_RESET = 0, P_NOWRITE = 1, P_IDLE = 2, P_TIMEOUT = 3;

  exp_t        sb[$];
  int          pq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          writes = 0;
  int          last_done = 0;
  logic [31:0] last_wdat = 32'h0;
  logic [31:0] last_waddr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge CLK) begin : monitor
    int p;
    exp_t e;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      case (p)
        P_RESET: begin
          chk("reset_ready", 32'(Ready), 32'd1);
          chk("reset_done", 32'(Done), 32'd0);
          chk("reset_fault", 32'(Fault), 32'd0);
          chk("reset_rdata", RData, 32'h0);
          chk("reset_memwrite", 32'(MemWrite), 32'd0);
          chk("reset_memaddress", MemAddress, 32'h0);
        end
        P_NOWRITE: chk("abort_memwrite", 32'(MemWrite), 32'd0);
        P_IDLE: begin
          chk("abort_ready", 32'(Ready), 32'd1);
          chk("abort_no_done", 32'(Done), 32'd0);
        end
        default: chk("timeout", 32'd1, 32'd0);
      endcase
    end
    if (MemWrite === 1'b1) begin
      writes++;
      last_wdat  = MemWriteData;
      last_waddr = MemAddress;
    end
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_fault", e.id), 32'(Fault), 32'(e.fault));
        chk($sformatf("op%0d_rdata", e.id), RData, e.rdata);
        chk($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.done_cyc));
        chk($sformatf("op%0d_memwrite_count", e.id), 32'(writes), 32'(e.nwr));
        if (e.nwr > 0) begin
          chk($sformatf("op%0d_memwritedata", e.id), last_wdat, e.wdat);
          chk($sformatf("op%0d_memaddress", e.id), last_waddr, e.waddr);
        end
        if (e.gap > 0) chk($sformatf("op%0d_back_to_back", e.id), 32'(cyc - last_done), 32'(e.gap));
      end
      writes    = 0;
      last_done = cyc;
    end
  end

  int          op_id = 0;
  logic [31:0] exp_rd = 32'h0;

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, input logic flt, input int lat, input int nwr,
                       input logic [31:0] wdat, input int gap, input bit track);
    exp_t e;
    int guard = 0;
    while (Ready !== 1'b1 && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 20) pq.push_back(P_TIMEOUT);
    Req = 1'b1; Write = wr; Size = sz; SignExt = sx; Addr = a; WData = wd;
    @(posedge CLK); #1;
    Req = 1'b0;
    if (track) begin
      op_id++;
      e.fault = flt; e.rdata = exp_rd; e.done_cyc = cyc + lat; e.nwr = nwr;
      e.wdat = wdat; e.waddr = {2'b00, a[31:2]}; e.gap = gap; e.id = op_id;
      sb.push_back(e);
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] rd, input int gap);
    exp_rd = rd;
    issue(1'b0, sz, sx, a, 32'h0, 1'b0, 1, 0, 32'h0, gap, 1'b1);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] merged);
    issue(1'b1, sz, 1'b0, a, wd, 1'b0, (sz == 2'b10) ? 1 : 2, 1, merged, 0, 1'b1);
  endtask

  task automatic flt(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    issue(wr, sz, 1'b0, a, 32'h12345678, 1'b1, 0, 0, 32'h0, 0, 1'b1);
  endtask

  initial begin
    int guard;
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    pq.push_back(P_RESET);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    st(2'b10, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 0);

    st(2'b10, 32'h8, 32'h11223344, 32'h11223344);
    st(2'b00, 32'h9, 32'h000000AA, 32'h1122AA44);
    ld(2'b00, 1'b1, 32'h9, 32'hFFFFFFAA, 0);
    ld(2'b00, 1'b0, 32'h9, 32'h000000AA, 0);

    st(2'b10, 32'h8, 32'h80017FFF, 32'h80017FFF);
    ld(2'b01, 1'b1, 32'hA, 32'hFFFF8001, 0);
    ld(2'b01, 1'b1, 32'h8, 32'h00007FFF, 2);
    ld(2'b01, 1'b0, 32'hA, 32'h00008001, 2);
    ld(2'b00, 1'b1, 32'hB, 32'hFFFFFF80, 2);
    ld(2'b00, 1'b1, 32'h8, 32'hFFFFFFFF, 2);

    flt(1'b0, 2'b01, 32'h3);
    flt(1'b1, 2'b10, 32'h20);
    flt(1'b0, 2'b11, 32'h0);
    flt(1'b0, 2'b10, 32'h2);
    flt(1'b1, 2'b00, 32'hFFFFFFFC);

    st(2'b10, 32'h1C, 32'h00000000, 32'h00000000);
    st(2'b00, 32'h1F, 32'h0000005A, 32'h5A000000);
    ld(2'b10, 1'b0, 32'h1C, 32'h5A000000, 0);

    st(2'b10, 32'h4, 32'hCAFEF00D, 32'hCAFEF00D);
    issue(1'b1, 2'b01, 1'b0, 32'h4, 32'h0000BEEF, 1'b0, 2, 1, 32'h0, 0, 1'b0);
    @(posedge CLK); #1;
    RESETn = 1'b0;
    pq.push_back(P_NOWRITE);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    pq.push_back(P_IDLE);
    @(posedge CLK); #1;
    pq.push_back(P_IDLE);
    ld(2'b10, 1'b0, 32'h4, 32'hCAFEF00D, 0);
    st(2'b01, 32'h6, 32'h00001234, 32'h1234F00D);
    ld(2'b10, 1'b0, 32'h4, 32'h1234F00D, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (sb.size() > 0) pq.push_back(P_TIMEOUT);
    repeat (2) @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
